// File: rtl/tdm_pkg.sv
// Shared constants and the slot index type for the 1:4 TDM receive demux.
package tdm_pkg;
    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] slot_t;
endpackage

// File: rtl/demux_1_4.sv
// Slot select to one-hot lane write-enable decoder, gated by the accept strobe.
module demux_1_4
    import tdm_pkg::*;
(
    input  logic             en,
    input  slot_t            sel,
    output logic [LANES-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_1_4.sv
// Receive end of a 4:1 TDM link: assembles four serial samples into one frame.
// Build option: TDM_STRICT_SOF_EN rejects slot-0 samples that lack in_sof.
module tdm_demux_1_4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output slot_t                    slot,
    output logic                     frame_err
);

    slot_t            slot_q;
    logic [WIDTH-1:0] asm_lane [0:LANES-2];
    logic             acc;
    logic             resync;
    logic             drop;
    logic             take;
    slot_t            wr_sel;
    logic [LANES-1:0] we;

    assign slot     = slot_q;
    assign in_ready = !(slot_q == slot_t'(LANES - 1) && out_valid && !out_ready);
    assign acc      = in_valid && in_ready;
    assign resync   = acc && in_sof && (slot_q != '0);

`ifdef TDM_STRICT_SOF_EN
    assign drop = acc && !in_sof && (slot_q == '0);
`else
    assign drop = 1'b0;
`endif

    assign take = acc && !drop;
    // A resync sample restarts the frame, so it always lands in lane 0.
    assign wr_sel = resync ? '0 : slot_q;

    demux_1_4 u_demux (
        .en  (take),
        .sel (wr_sel),
        .we  (we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < LANES - 1; i++) begin
                asm_lane[i] <= '0;
            end
        end else begin
            frame_err <= resync || drop;
            if (take) begin
                slot_q <= resync ? slot_t'(1) : slot_q + slot_t'(1);
            end
            for (int unsigned i = 0; i < LANES - 1; i++) begin
                if (we[i]) begin
                    asm_lane[i] <= in_data;
                end
            end
            // Lane 3 bypasses assembly and completes the frame directly.
            if (we[LANES-1]) begin
                out_data  <= {in_data, asm_lane[2], asm_lane[1], asm_lane[0]};
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Scoreboard bench for tdm_demux_1_4: sample-queue reference model plus output monitor.
module tb_tdm_demux_1_4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic [3:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  slot;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    logic [3:0]  part [$];
    logic [15:0] sb   [$];
    logic        m_ov  = 1'b0;
    logic        m_err = 1'b0;

    tdm_demux_1_4 #(.WIDTH(4), .LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .slot      (slot),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; checks DUT state against the model, then advances the model.
    task automatic cycle(input logic v, input logic s, input logic [3:0] d, input logic ordy,
                         output logic handshake);
        logic exp_rdy;
        logic done;
        @(negedge clk);
        rst = 1'b0; in_valid = v; in_sof = s; in_data = d; out_ready = ordy;
        #2;
        chk("slot", 16'(slot), 16'(part.size()));
        chk("out_valid", 16'(out_valid), 16'(m_ov));
        chk("frame_err", 16'(frame_err), 16'(m_err));
        exp_rdy = !(part.size() == 3 && m_ov && !ordy);
        chk("in_ready", 16'(in_ready), 16'(exp_rdy));
        handshake = v && exp_rdy;
        m_err = 1'b0;
        done  = 1'b0;
        if (handshake) begin
            if (s && part.size() != 0) begin
                part.delete();
                m_err = 1'b1;
            end
`ifdef TDM_STRICT_SOF_EN
            if (!s && part.size() == 0) begin
                m_err = 1'b1;
            end else
`endif
            begin
                part.push_back(d);
                if (part.size() == 4) begin
                    sb.push_back({part[3], part[2], part[1], part[0]});
                    part.delete();
                    done = 1'b1;
                end
            end
        end
        if (done) m_ov = 1'b1;
        else if (m_ov && ordy) m_ov = 1'b0;
    endtask

    task automatic send(input logic s, input logic [3:0] d, input logic ordy);
        logic hs;
        int   tries;
        tries = 0;
        hs = 1'b0;
        while (!hs && tries < 50) begin
            cycle(1'b1, s, d, ordy, hs);
            tries++;
        end
        if (!hs) begin
            errors++;
            $display("FAIL send_timeout: sample %h not accepted after %0d cycles", d, tries);
        end
    endtask

    task automatic idle(input logic ordy, input int n);
        logic hs;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, ordy, hs);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
        #2;
        part.delete();
        sb.delete();
        m_ov  = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_slot", 16'(slot), 16'h0);
        chk("rst_in_ready", 16'(in_ready), 16'h1);
        chk("rst_frame_err", 16'(frame_err), 16'h0);
    endtask

    // Monitor: checks the presented frame each cycle, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: out_valid with data %h but no frame expected", out_data);
                end else begin
                    chk("out_data", out_data, sb[0]);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic hs;
        do_reset();

        // Single frame, then two back-to-back frames.
        send(1'b1, 4'h1, 1'b1); send(1'b0, 4'h2, 1'b1);
        send(1'b0, 4'h3, 1'b1); send(1'b0, 4'h4, 1'b1);
        idle(1'b1, 2);
        for (int i = 1; i <= 8; i++) send(i == 1 || i == 5, 4'(i), 1'b1);
        idle(1'b1, 2);

        // Backpressure: frame 1 held while frame 2 stalls on its last sample.
        for (int i = 1; i <= 4; i++) send(i == 1, 4'(i), 1'b0);
        for (int i = 5; i <= 7; i++) send(i == 5, 4'(i), 1'b0);
        cycle(1'b1, 1'b0, 4'h8, 1'b0, hs);
        chk("stall_hs", 16'(hs), 16'h0);
        idle(1'b0, 3);
        chk("hold_data", out_data, 16'h4321);
        send(1'b0, 4'h8, 1'b1);
        idle(1'b1, 3);

        // Resync: sof mid-frame restarts at lane 0.
        send(1'b1, 4'h1, 1'b1); send(1'b0, 4'h2, 1'b1);
        send(1'b1, 4'h9, 1'b1);
        send(1'b0, 4'hA, 1'b1); send(1'b0, 4'hB, 1'b1); send(1'b0, 4'hC, 1'b1);
        idle(1'b1, 2);

        // Reset mid-frame with a pending output, then a clean frame.
        for (int i = 1; i <= 4; i++) send(i == 1, 4'(i), 1'b0);
        send(1'b1, 4'h5, 1'b0); send(1'b0, 4'h6, 1'b0); send(1'b0, 4'h7, 1'b0);
        do_reset();
        for (int i = 1; i <= 4; i++) send(i == 1, 4'(i + 4), 1'b1);
        idle(1'b1, 2);

        // Slot-0 sample without sof (behaviour depends on the strict build option).
        do_reset();
        send(1'b0, 4'hD, 1'b1);
        idle(1'b1, 2);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                      4'($urandom), $urandom_range(0, 3) != 0, hs);
            end
        end

        idle(1'b1, 4);
        chk("sb_drained", 16'(sb.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
